// File: rtl/sprite_scan_scheduler.sv
// Per-line sprite attribute scan: fills up to MAX_SLOTS active slots for the next video line.
// Optional macro SPRITE_SCAN_EARLY_EXIT_EN: stop scanning as soon as every slot is filled.
module sprite_scan_scheduler #(
  parameter int NUM_SPRITES = 32,
  parameter int MAX_SLOTS   = 8,
  parameter int SPRITE_H    = 32,
  parameter int V_TOTAL     = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  VGA_VCOUNT,
  output logic [4:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic        slot_we,
  output logic [2:0]  slot_idx,
  output logic [23:0] slot_data,
  output logic [3:0]  slot_count,
  output logic        overflow,
  output logic        done
);

  localparam logic [4:0]  LAST_ADDR = 5'(NUM_SPRITES - 1);
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_SLOTS);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [10:0] H_SPAN    = 11'(SPRITE_H - 1);
`ifdef SPRITE_SCAN_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
  localparam logic KEEP_OVF   = 1'b0;
`else
  localparam logic EARLY_EXIT = 1'b0;
  localparam logic KEEP_OVF   = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Vertical coverage test; 11-bit math so y+SPRITE_H-1 never wraps past line 1023.
  function automatic logic sprite_hit(input logic [4:0] id, input logic [9:0] y,
                                      input logic [9:0] target);
    logic [10:0] tgt_w;
    logic [10:0] top_w;
    logic [10:0] bot_w;
    tgt_w = {1'b0, target};
    top_w = {1'b0, y};
    bot_w = top_w + H_SPAN;
    return (id != 5'd0) && (tgt_w >= top_w) && (tgt_w <= bot_w);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [4:0]  addr_r, addr_nxt_s;
  logic [3:0]  count_r, count_nxt_s;
  logic        ovf_r, ovf_nxt_s;
  logic        eval_r, eval_nxt_s;
  logic [9:0]  target_r, target_nxt_s;
  logic [3:0]  slot_count_r, slot_count_nxt_s;
  logic        overflow_r, overflow_nxt_s;
  logic        hit_s;
  logic        wr_s;
  logic        full_s;
  logic        early_stop_s;
  logic [10:0] next_line_s;

  // eval_r marks that tbl_data carries the entry addressed in the previous cycle.
  assign hit_s        = eval_r && sprite_hit(tbl_data[23:19], tbl_data[9:0], target_r);
  assign wr_s         = hit_s && (count_r < MAX_CNT);
  assign full_s       = hit_s && (count_r >= MAX_CNT);
  assign early_stop_s = EARLY_EXIT && wr_s && (count_r == (MAX_CNT - 4'd1));
  assign next_line_s  = {1'b0, VGA_VCOUNT} + 11'd1;

  // Next-state, scan address, slot counting and commit logic.
  always_comb begin
    state_nxt_s      = state_r;
    addr_nxt_s       = addr_r;
    count_nxt_s      = count_r;
    ovf_nxt_s        = ovf_r;
    eval_nxt_s       = eval_r;
    target_nxt_s     = target_r;
    slot_count_nxt_s = slot_count_r;
    overflow_nxt_s   = overflow_r;

    case (state_r)
      IDLE: begin
        addr_nxt_s = 5'd0;
        eval_nxt_s = 1'b0;
      end
      SCAN: begin
        if (early_stop_s) begin
          state_nxt_s = DONE;
          addr_nxt_s  = 5'd0;
          eval_nxt_s  = 1'b0;
        end else if (addr_r == LAST_ADDR) begin
          state_nxt_s = DRAIN;
          eval_nxt_s  = 1'b1;
        end else begin
          addr_nxt_s = addr_r + 5'd1;
          eval_nxt_s = 1'b1;
        end
      end
      DRAIN: begin
        state_nxt_s = DONE;
        addr_nxt_s  = 5'd0;
        eval_nxt_s  = 1'b0;
      end
      DONE: begin
        state_nxt_s      = IDLE;
        addr_nxt_s       = 5'd0;
        eval_nxt_s       = 1'b0;
        slot_count_nxt_s = count_r;
        overflow_nxt_s   = ovf_r & KEEP_OVF;
      end
      default: begin
        state_nxt_s = IDLE;
        addr_nxt_s  = 5'd0;
        eval_nxt_s  = 1'b0;
      end
    endcase

    if (wr_s) begin
      count_nxt_s = count_r + 4'd1;
    end else begin
      count_nxt_s = count_r;
    end

    if (full_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    // A new line always wins: any scan in flight is abandoned without committing.
    if (line_start) begin
      state_nxt_s  = SCAN;
      target_nxt_s = (next_line_s == V_TOTAL_W) ? 10'd0 : next_line_s[9:0];
      count_nxt_s  = 4'd0;
      ovf_nxt_s    = 1'b0;
      addr_nxt_s   = 5'd0;
      eval_nxt_s   = 1'b0;
    end else begin
      target_nxt_s = target_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      addr_r       <= 5'd0;
      count_r      <= 4'd0;
      ovf_r        <= 1'b0;
      eval_r       <= 1'b0;
      target_r     <= 10'd0;
      slot_count_r <= 4'd0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      count_r      <= count_nxt_s;
      ovf_r        <= ovf_nxt_s;
      eval_r       <= eval_nxt_s;
      target_r     <= target_nxt_s;
      slot_count_r <= slot_count_nxt_s;
      overflow_r   <= overflow_nxt_s;
    end
  end

  assign tbl_addr   = addr_r;
  assign slot_we    = wr_s;
  assign slot_idx   = wr_s ? count_r[2:0] : 3'd0;
  assign slot_data  = wr_s ? tbl_data : 24'd0;
  assign slot_count = slot_count_r;
  assign overflow   = overflow_r;
  assign done       = (state_r == DONE);

endmodule

// File: doc/sprite_scan_scheduler.md
SPRITE_SCAN_SCHEDULER -- requirements
Module: sprite_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 32, the number of sprite attribute table entries scanned per line.
REQ-002 SHALL have parameter MAX_SLOTS, default 8, the number of active-slot entries per line.
REQ-003 SHALL have parameter SPRITE_H, default 32, the sprite height in lines.
REQ-004 SHALL have parameter V_TOTAL, default 525, the total line count per frame.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have port line_start, input, 1, a one-cycle pulse at the start of each line.
REQ-008 SHALL have port VGA_VCOUNT, input, 10, the current line number, sampled on line_start.
REQ-009 SHALL have port tbl_addr, output, 5, the sprite attribute table read address.
REQ-010 SHALL have port tbl_data, input, 24, the attribute {id[23:19], x[18:10], y[9:0]}, valid 1 cycle after tbl_addr.
REQ-011 SHALL have port slot_we, output, 1, the active-slot write strobe.
REQ-012 SHALL have port slot_idx, output, 3, the active-slot write index.
REQ-013 SHALL have port slot_data, output, 24, the attribute word written to the slot.
REQ-014 SHALL have port slot_count, output, 4, the committed count of valid slots for the next line (0..8).
REQ-015 SHALL have port overflow, output, 1, the committed flag meaning more than MAX_SLOTS sprites hit the next line.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse at scan completion.

Function
REQ-017 SHALL implement an FSM with states IDLE, SCAN, DRAIN and DONE.
REQ-018 SHALL, on line_start in any state, latch target = VGA_VCOUNT+1, or 0 if VGA_VCOUNT+1 == V_TOTAL; clear the internal count and overflow; set tbl_addr=0; and enter SCAN.
REQ-019 SHALL, in SCAN, increment tbl_addr by one per cycle; after issuing NUM_SPRITES-1 it SHALL enter DRAIN for 1 cycle and then DONE.
REQ-020 SHALL evaluate each returned tbl_data one cycle after its address as a hit when id != 0, target >= y and target <= y+SPRITE_H-1, using 11-bit unsigned compare with no wrap.
REQ-021 SHALL, on a hit with internal count < MAX_SLOTS, assert slot_we for one cycle with slot_idx = count and slot_data = tbl_data, then increment count.
REQ-022 SHALL, on a hit with count == MAX_SLOTS, write no slot and set the internal overflow.
REQ-023 SHALL fill slots in ascending table order; lower index has priority.
REQ-024 SHALL, in DONE, copy count to slot_count and the internal overflow to overflow, pulse done for 1 cycle, and return to IDLE.
REQ-025 SHALL give latency, with line_start at cycle 0: tbl_addr=k at cycle k+1; the last slot_we at cycle NUM_SPRITES+1 or earlier; done at cycle NUM_SPRITES+2 (34 by default).
REQ-026 SHALL, on line_start during SCAN or DRAIN, abort the scan: no done pulse for the aborted scan, slot_count and overflow unchanged, new scan restarted per REQ-018.
REQ-027 SHALL keep slot_count and overflow stable between done pulses.
REQ-028 SHALL hold tbl_addr at 0 and slot_we at 0 in IDLE.

Reset
REQ-029 SHALL, while reset=0, force the FSM to IDLE and tbl_addr, slot_we, slot_idx, slot_data, slot_count, overflow and done to 0, independent of clk.
REQ-030 SHALL, on reset mid-scan, discard the scan; operation resumes only on the next line_start after reset release.

Configuration
REQ-031 SHALL, with macro SPRITE_SCAN_EARLY_EXIT_EN defined, leave SCAN on the cycle the MAX_SLOTS-th slot_we asserts, issuing no further reads, go to DONE the next cycle, and hold overflow at 0.
REQ-032 SHALL, without SPRITE_SCAN_EARLY_EXIT_EN, always scan all NUM_SPRITES entries per REQ-019 and REQ-025.

Verification
REQ-033 SHALL verify: VCOUNT=99, entry 3 = {id 1, x 40, y 80}, other entries id 0 -> one slot_we, idx 0, data = entry 3; done at cycle 34; slot_count=1, overflow=0.
REQ-034 SHALL verify: target 100, y=69 (last line 100) hits; y=68 and y=101 miss -> slot_count=1.
REQ-035 SHALL verify: 10 sprites at y=0 in entries 0..9, VCOUNT=5 -> slots 0..7 = entries 0..7, slot_count=8, overflow=1 (with early exit: done at cycle 10, overflow=0).
REQ-036 SHALL verify: VCOUNT=524 -> target 0; sprite y=0 hits.
REQ-037 SHALL verify: line_start again at cycle 10 -> no done at cycle 34; done at cycle 44; prior slot_count held until then.
REQ-038 SHALL verify: reset=0 asserted at cycle 15 mid-scan -> all outputs 0 asynchronously; no done until a new line_start.
